sar_adc_seq: RTL and testbench

//   Digital sequencer and sample buffer directly downstream of the sar_10b macro.
//   - Drives the macro's en/cal pins and paces conversions at a programmable period.
//   - Captures each 10-bit result, averages 2^AVG_LOG2 results and queues the averages in a small FIFO.
//   - The node's sensor logic pops averaged samples from the FIFO with a valid/ready handshake.
//

---
 rtl/sar_adc_seq.sv | 248 ++++++++++++++++++++++++
 tb/tb_sar_adc_seq.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_seq.sv
`default_nettype none
// ============================================================================
// Module   : sar_adc_seq
// Brief    : Sequencer for the sar_10b macro. It paces conversions, averages
//            2^AVG_LOG2 results and queues the averages in a show-ahead FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module sar_adc_seq #(
    parameter int AVG_LOG2   = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CAL_CYCLES = 16,
    parameter int TIMEOUT    = 255,
    parameter int PERIOD_W   = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                cal_req,
    input  logic [PERIOD_W-1:0] period,
    input  logic                clr_err,
    output logic                adc_en,
    output logic                adc_cal,
    input  logic                adc_valid,
    input  logic [9:0]          adc_result,
    output logic [9:0]          smp_data,
    output logic                smp_valid,
    input  logic                smp_ready,
    output logic                busy,
    output logic                overflow,
    output logic                timeout_err
);

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int ACC_W = 10 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMR_W = max_int(PERIOD_W,
                           max_int($clog2(TIMEOUT + 1), $clog2(CAL_CYCLES + 1)));

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CAL  = 2'd1;
    localparam logic [1:0] S_CONV = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    logic [1:0]          state;
    logic [1:0]          next_state;
    logic                valid_meta;
    logic                valid_sync;
    logic                valid_prev;
    logic                valid_edge;
    logic                cal_pend;
    logic                enter_cal;
    logic [TMR_W-1:0]    timer;
    logic [PERIOD_W-1:0] eff_period;
    logic                cal_done;
    logic                conv_done;
    logic                conv_timeout;
    logic                wait_done;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_inc;
    logic                avg_full;
    logic                push;
    logic [9:0]          push_data;
    logic                push_ok;
    logic                pop;
    logic                full;
    logic                ovf_set;
    logic [9:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wptr;
    logic [PTR_W-1:0]    rptr;
    logic [OCC_W-1:0]    occ;

    // adc_valid comes from the macro's own timing domain: synchronise, then edge-detect
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_meta <= 1'b0;
            valid_sync <= 1'b0;
            valid_prev <= 1'b0;
        end else begin
            valid_meta <= adc_valid;
            valid_sync <= valid_meta;
            valid_prev <= valid_sync;
        end
    end

    assign valid_edge   = valid_sync & ~valid_prev;
    assign eff_period   = (period == '0) ? PERIOD_W'(1) : period;
    assign cal_done     = (state == S_CAL)  && (timer >= TMR_W'(CAL_CYCLES));
    assign conv_done    = (state == S_CONV) && valid_edge;
    assign conv_timeout = (state == S_CONV) && !valid_edge && (timer >= TMR_W'(TIMEOUT));
    assign wait_done    = (state == S_WAIT) && (timer >= TMR_W'(eff_period));
    assign enter_cal    = (next_state == S_CAL) && (state != S_CAL);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (cal_pend) begin
                    next_state = S_CAL;
                end else if (start) begin
                    next_state = S_CONV;
                end
            end
            S_CAL: begin
                if (cal_done) begin
                    next_state = S_IDLE;
                end
            end
            S_CONV: begin
                if (conv_done) begin
                    next_state = S_WAIT;
                end else if (conv_timeout) begin
                    next_state = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wait_done) begin
                    if (cal_pend) begin
                        next_state = S_CAL;
                    end else if (start) begin
                        next_state = S_CONV;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Decoded straight from the state register so reset drops the macro pins at once
    always_comb begin
        adc_en  = 1'b0;
        adc_cal = 1'b0;
        busy    = 1'b1;
        case (state)
            S_IDLE:  busy = 1'b0;
            S_CAL: begin
                adc_en  = 1'b1;
                adc_cal = 1'b1;
            end
            S_CONV:  adc_en = 1'b1;
            S_WAIT:  adc_en = 1'b0;
            default: busy = 1'b0;
        endcase
    end

    // Timer holds the 1-based cycle count within the current state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer <= '0;
        end else if (next_state != state) begin
            timer <= TMR_W'(1);
        end else if (state != S_IDLE) begin
            timer <= timer + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cal_pend <= 1'b0;
        end else begin
            cal_pend <= cal_req | (cal_pend & ~enter_cal);
        end
    end

    assign acc_sum   = acc + ACC_W'(adc_result);
    assign cnt_inc   = cnt + CNT_W'(1);
    assign avg_full  = (cnt_inc == CNT_W'(1 << AVG_LOG2));
    assign push      = conv_done && avg_full;
    assign push_data = acc_sum[ACC_W-1:AVG_LOG2];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc <= '0;
            cnt <= '0;
        end else if (conv_done) begin
            if (avg_full) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= acc_sum;
                cnt <= cnt_inc;
            end
        end else if (conv_timeout || ((state == S_WAIT) && (next_state == S_IDLE))) begin
            acc <= '0;
            cnt <= '0;
        end
    end

    // A push into a full FIFO only lands if the head leaves in the same cycle
    assign full      = (occ == OCC_W'(FIFO_DEPTH));
    assign smp_valid = (occ != '0);
    assign pop       = smp_valid & smp_ready;
    assign push_ok   = push & (~full | pop);
    assign ovf_set   = push & full & ~pop;
    assign smp_data  = mem[rptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (push_ok) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            overflow    <= (overflow & ~clr_err) | ovf_set;
            timeout_err <= (timeout_err & ~clr_err) | conv_timeout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sar_adc_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_adc_seq
// Brief    : Directed bench for sar_adc_seq; two instances (AVG_LOG2=2 and 0)
//            share stimulus and a behavioural sar_10b macro.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_adc_seq;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        cal_req;
    logic [15:0] period;
    logic        clr_err;
    logic        adc_valid;
    logic [9:0]  adc_result;
    logic        ready_a, ready_b;
    logic        en_a, cal_a, valid_a, busy_a, ovf_a, tmo_a;
    logic        en_b, cal_b, valid_b, busy_b, ovf_b, tmo_b;
    logic [9:0]  data_a, data_b;

    int          checks = 0;
    int          errors = 0;
    logic [9:0]  res_q[$];
    bit          mute;
    int          lat;

    always #5 clk = ~clk;

    sar_adc_seq #(.AVG_LOG2(2)) dut (
        .clk(clk), .rstn(rstn), .start(start), .cal_req(cal_req), .period(period),
        .clr_err(clr_err), .adc_en(en_a), .adc_cal(cal_a), .adc_valid(adc_valid),
        .adc_result(adc_result), .smp_data(data_a), .smp_valid(valid_a),
        .smp_ready(ready_a), .busy(busy_a), .overflow(ovf_a), .timeout_err(tmo_a)
    );

    sar_adc_seq #(.AVG_LOG2(0)) dut0 (
        .clk(clk), .rstn(rstn), .start(start), .cal_req(cal_req), .period(period),
        .clr_err(clr_err), .adc_en(en_b), .adc_cal(cal_b), .adc_valid(adc_valid),
        .adc_result(adc_result), .smp_data(data_b), .smp_valid(valid_b),
        .smp_ready(ready_b), .busy(busy_b), .overflow(ovf_b), .timeout_err(tmo_b)
    );

    // Macro model: result appears 4 cycles into a conversion, held until en drops
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            adc_valid  <= 1'b0;
            adc_result <= '0;
            lat        <= 0;
        end else if (!en_a || cal_a) begin
            adc_valid <= 1'b0;
            lat       <= 0;
        end else if (!adc_valid && !mute) begin
            if (lat == 3) begin
                adc_valid  <= 1'b1;
                adc_result <= (res_q.size() > 0) ? res_q.pop_front() : 10'd0;
            end else begin
                lat <= lat + 1;
            end
        end
    end

    function automatic logic sig(input int which);
        case (which)
            0:       return en_a;
            1:       return busy_a;
            2:       return adc_valid;
            3:       return valid_b;
            default: return ovf_a;
        endcase
    endfunction

    task automatic wait_for(input int which, input logic val, input int limit, input string name);
        int n = 0;
        while (sig(which) !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (sig(which) !== val) begin
            checks++;
            errors++;
            $display("FAIL %s: wait expired after %0d cycles, want %b", name, limit, val);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; start = 1'b0; cal_req = 1'b0; clr_err = 1'b0;
        ready_a = 1'b0; ready_b = 1'b0; period = 16'd1; mute = 1'b0;
        res_q.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (en_a !== 1'b0)  begin errors++; $display("FAIL rst_en: got %b want 0", en_a); end
        checks++; if (cal_b !== 1'b0) begin errors++; $display("FAIL rst_cal: got %b want 0", cal_b); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid_a); end
        checks++; if (data_a !== 10'd0) begin errors++; $display("FAIL rst_data: got %0d want 0", data_a); end
        checks++; if ({busy_a, busy_b, ovf_a, tmo_a} !== 4'b0) begin
            errors++; $display("FAIL rst_flags: got %b want 0000", {busy_a, busy_b, ovf_a, tmo_a});
        end
        // Reset in the middle of a later conversion, with dut0 holding a sample
        for (int i = 0; i < 8; i++) res_q.push_back(10'(i + 1));
        start = 1'b1;
        wait_for(3, 1'b1, 200, "rst_wait_sample");
        wait_for(0, 1'b0, 50, "rst_wait_wait");
        wait_for(0, 1'b1, 50, "rst_wait_conv");
        #1 rstn = 1'b0;
        #1;
        checks++; if ({en_a, cal_a, en_b, cal_b} !== 4'b0) begin
            errors++; $display("FAIL rst_async_pins: got %b want 0000", {en_a, cal_a, en_b, cal_b});
        end
        checks++; if ({valid_b, busy_a, ovf_b, tmo_b} !== 4'b0) begin
            errors++; $display("FAIL rst_async_status: got %b want 0000", {valid_b, busy_a, ovf_b, tmo_b});
        end
        @(negedge clk);
        start = 1'b0;
        rstn  = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({valid_a, valid_b, busy_a} !== 3'b0) begin
            errors++; $display("FAIL rst_release: got %b want 000", {valid_a, valid_b, busy_a});
        end
    endtask

    task automatic test_average();
        int n = 0, low_run = 0, ngaps = 0, gmin = 9999, gmax = 0;
        bit seen_high = 0;
        logic [9:0] exp_b [4] = '{10'd100, 10'd101, 10'd102, 10'd103};
        do_reset();
        period = 16'd10;
        for (int i = 0; i < 4; i++) res_q.push_back(10'(100 + i));
        start = 1'b1;
        while (!valid_a && n < 600) begin
            @(negedge clk);
            n++;
            if (en_a) begin
                if (seen_high && low_run > 0) begin
                    ngaps++;
                    if (low_run < gmin) gmin = low_run;
                    if (low_run > gmax) gmax = low_run;
                end
                low_run   = 0;
                seen_high = 1;
            end else if (seen_high) begin
                low_run++;
            end
        end
        start = 1'b0;
        wait_for(1, 1'b0, 100, "avg_idle");
        checks++; if (ngaps != 3 || gmin != 10 || gmax != 10) begin
            errors++; $display("FAIL avg_gap: got n=%0d min=%0d max=%0d want n=3 min=10 max=10", ngaps, gmin, gmax);
        end
        checks++; if (valid_a !== 1'b1 || data_a !== 10'd101) begin
            errors++; $display("FAIL avg_value: got valid=%b data=%0d want 1/101", valid_a, data_a);
        end
        ready_a = 1'b1; @(negedge clk); ready_a = 1'b0;
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL avg_single: got valid=%b want 0", valid_a); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (valid_b !== 1'b1 || data_b !== exp_b[i]) begin
                errors++; $display("FAIL avg0_pop%0d: got %b/%0d want 1/%0d", i, valid_b, data_b, exp_b[i]);
            end
            ready_b = 1'b1; @(negedge clk); ready_b = 1'b0;
        end
        checks++; if (valid_b !== 1'b0 || ovf_b !== 1'b0) begin
            errors++; $display("FAIL avg0_drained: got valid=%b ovf=%b want 0/0", valid_b, ovf_b);
        end
    endtask

    task automatic test_cal();
        int ncal = 0, nen = 0, nlow = 0;
        do_reset();
        cal_req = 1'b1; @(negedge clk); cal_req = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cal_a) ncal++;
            if (en_a) nen++;
            if (ncal > 0 && !busy_a) break;
        end
        checks++; if (ncal != 16 || nen != 16) begin
            errors++; $display("FAIL cal_len: got cal=%0d en=%0d want 16/16", ncal, nen);
        end
        checks++; if (busy_a !== 1'b0 || en_a !== 1'b0) begin
            errors++; $display("FAIL cal_idle: got busy=%b en=%b want 0/0", busy_a, en_a);
        end
        // Request arriving mid-conversion is served after the following WAIT
        period = 16'd3;
        for (int i = 0; i < 4; i++) res_q.push_back(10'd5);
        start = 1'b1;
        wait_for(0, 1'b1, 20, "cal_conv");
        cal_req = 1'b1; @(negedge clk); cal_req = 1'b0;
        wait_for(0, 1'b0, 30, "cal_conv_end");
        while (!en_a && nlow < 20) begin
            nlow++;
            @(negedge clk);
        end
        checks++; if (cal_a !== 1'b1 || nlow != 3) begin
            errors++; $display("FAIL cal_after_wait: got cal=%b low=%0d want 1/3", cal_a, nlow);
        end
        start = 1'b0;
        wait_for(1, 1'b0, 40, "cal2_idle");
        repeat (3) @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL cal_collapse: got busy=%b want 0", busy_a); end
    endtask

    task automatic test_timeout();
        int nen = 0;
        do_reset();
        mute  = 1'b1;
        start = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (tmo_a) break;
            if (en_a) nen++;
        end
        start = 1'b0;
        checks++; if (tmo_a !== 1'b1 || nen != 255) begin
            errors++; $display("FAIL tmo_len: got err=%b en_cycles=%0d want 1/255", tmo_a, nen);
        end
        checks++; if (en_a !== 1'b0 || busy_a !== 1'b0 || tmo_b !== 1'b1) begin
            errors++; $display("FAIL tmo_idle: got en=%b busy=%b err0=%b want 0/0/1", en_a, busy_a, tmo_b);
        end
        clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
        checks++; if (tmo_a !== 1'b0 || tmo_b !== 1'b0) begin
            errors++; $display("FAIL tmo_clear: got %b%b want 00", tmo_a, tmo_b);
        end
    endtask

    task automatic test_overflow();
        logic [9:0] exp_a [4] = '{10'd11, 10'd21, 10'd31, 10'd41};
        logic [9:0] exp_b [4] = '{10'd11, 10'd12, 10'd13, 10'd77};
        do_reset();
        for (int k = 0; k < 5; k++)
            for (int j = 0; j < 4; j++) res_q.push_back(10'(10 * (k + 1) + j));
        start = 1'b1;
        wait_for(4, 1'b1, 3000, "ovf_wait");
        start = 1'b0;
        wait_for(1, 1'b0, 50, "ovf_idle");
        checks++; if (ovf_a !== 1'b1 || ovf_b !== 1'b1) begin
            errors++; $display("FAIL ovf_set: got %b%b want 11", ovf_a, ovf_b);
        end
        clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
        checks++; if (ovf_a !== 1'b0 || ovf_b !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: got %b%b want 00", ovf_a, ovf_b);
        end
        // Pop dut0's head in exactly the cycle its next sample is pushed
        res_q.push_back(10'd77);
        start = 1'b1;
        wait_for(2, 1'b1, 50, "ovf_valid");
        start = 1'b0;
        repeat (2) @(negedge clk);
        ready_b = 1'b1; @(negedge clk); ready_b = 1'b0;
        wait_for(1, 1'b0, 50, "ovf_idle2");
        checks++; if (ovf_b !== 1'b0) begin errors++; $display("FAIL ovf_pushpop: got %b want 0", ovf_b); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (valid_b !== 1'b1 || data_b !== exp_b[i]) begin
                errors++; $display("FAIL ovf0_pop%0d: got %b/%0d want 1/%0d", i, valid_b, data_b, exp_b[i]);
            end
            ready_b = 1'b1; @(negedge clk); ready_b = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (valid_a !== 1'b1 || data_a !== exp_a[i]) begin
                errors++; $display("FAIL ovf_pop%0d: got %b/%0d want 1/%0d", i, valid_a, data_a, exp_a[i]);
            end
            ready_a = 1'b1; @(negedge clk); ready_a = 1'b0;
        end
        checks++; if (valid_a !== 1'b0 || valid_b !== 1'b0) begin
            errors++; $display("FAIL ovf_drained: got %b%b want 00", valid_a, valid_b);
        end
    endtask

    task automatic test_no_avg_and_stop();
        int falls = 0;
        logic prev = 1'b0;
        do_reset();
        period = 16'd2;
        res_q.push_back(10'd1023);
        res_q.push_back(10'd0);
        start = 1'b1;
        for (int n = 0; n < 200 && falls < 2; n++) begin
            @(negedge clk);
            if (prev && !en_a) falls++;
            prev = en_a;
        end
        start = 1'b0;
        wait_for(1, 1'b0, 50, "na_idle");
        checks++; if (valid_b !== 1'b1 || data_b !== 10'd1023) begin
            errors++; $display("FAIL na_first: got %b/%0d want 1/1023", valid_b, data_b);
        end
        ready_b = 1'b1; @(negedge clk); ready_b = 1'b0;
        checks++; if (valid_b !== 1'b1 || data_b !== 10'd0) begin
            errors++; $display("FAIL na_second: got %b/%0d want 1/0", valid_b, data_b);
        end
        ready_b = 1'b1; @(negedge clk); ready_b = 1'b0;
        checks++; if (valid_b !== 1'b0 || valid_a !== 1'b0) begin
            errors++; $display("FAIL na_empty: got b=%b a=%b want 0/0", valid_b, valid_a);
        end
        // start removed on the first CONV cycle; the conversion still finishes
        res_q.push_back(10'd5);
        start = 1'b1;
        wait_for(0, 1'b1, 20, "stop_conv");
        start = 1'b0;
        wait_for(1, 1'b0, 50, "stop_idle");
        repeat (2) @(negedge clk);
        checks++; if (busy_a !== 1'b0 || valid_b !== 1'b1 || data_b !== 10'd5) begin
            errors++; $display("FAIL stop_complete: got busy=%b valid=%b data=%0d want 0/1/5", busy_a, valid_b, data_b);
        end
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; cal_req = 1'b0; clr_err = 1'b0;
        ready_a = 1'b0; ready_b = 1'b0; period = 16'd1; mute = 1'b0;
        test_reset();
        test_average();
        test_cal();
        test_timeout();
        test_overflow();
        test_no_avg_and_stop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
